// File: rtl/memory_arbiter.sv
// Arbitrates the single external memory port between instruction fetch and the
// store buffer: one buffered request per port, one outstanding grant, data first.
module memory_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  output logic        imem_ready,
  output logic [31:0] imem_rdata,
  input  logic        dmem_valid,
  input  logic        dmem_fence,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic        dmem_ready,
  output logic [31:0] dmem_rdata,
  output logic        mem_valid,
  output logic        mem_fence,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t        state;
  logic [CW-1:0] starve_cnt;

  logic        i_pend;
  logic [31:0] i_addr;
  logic        d_pend;
  logic        d_fence;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;

  logic        i_ans, d_ans;
  logic        ni_pend, nd_pend;
  logic [31:0] ni_addr;
  logic        nd_fence;
  logic [31:0] nd_addr, nd_wdata;
  logic [3:0]  nd_wstrb;
  logic        grant_i, grant_d;

  // Grant decision looks at the slots as they will be after this cycle's
  // capture, so a request arriving in IDLE is granted at the same edge.
  always_comb begin
    i_ans    = (state == BUSY_I) && mem_ready;
    d_ans    = (state == BUSY_D) && mem_ready;
    ni_pend  = imem_valid | (i_pend & ~i_ans);
    ni_addr  = imem_valid ? imem_addr : i_addr;
    nd_pend  = dmem_valid | (d_pend & ~d_ans);
    nd_fence = dmem_valid ? dmem_fence : d_fence;
    nd_addr  = dmem_valid ? dmem_addr  : d_addr;
    nd_wdata = dmem_valid ? dmem_wdata : d_wdata;
    nd_wstrb = dmem_valid ? dmem_wstrb : d_wstrb;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    if (state == IDLE) begin
      if (ni_pend && nd_pend) begin
        if (starve_cnt == CW'(STARVE_MAX)) grant_i = 1'b1;
        else                               grant_d = 1'b1;
      end else if (ni_pend) begin
        grant_i = 1'b1;
      end else if (nd_pend) begin
        grant_d = 1'b1;
      end
    end
  end

  always_comb begin
    imem_ready = i_ans;
    imem_rdata = i_ans ? mem_rdata : '0;
    dmem_ready = d_ans;
    dmem_rdata = d_ans ? mem_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      i_pend     <= 1'b0;
      i_addr     <= '0;
      d_pend     <= 1'b0;
      d_fence    <= 1'b0;
      d_addr     <= '0;
      d_wdata    <= '0;
      d_wstrb    <= '0;
      mem_valid  <= 1'b0;
      mem_fence  <= 1'b0;
      mem_instr  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
    end else begin
      i_pend    <= ni_pend;
      i_addr    <= ni_addr;
      d_pend    <= nd_pend;
      d_fence   <= nd_fence;
      d_addr    <= nd_addr;
      d_wdata   <= nd_wdata;
      d_wstrb   <= nd_wstrb;
      mem_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_i) begin
            state     <= BUSY_I;
            mem_valid <= 1'b1;
            mem_instr <= 1'b1;
            mem_fence <= 1'b0;
            mem_addr  <= ni_addr;
            mem_wdata <= '0;
            mem_wstrb <= '0;
          end else if (grant_d) begin
            state     <= BUSY_D;
            mem_valid <= 1'b1;
            mem_instr <= 1'b0;
            mem_fence <= nd_fence;
            mem_addr  <= nd_addr;
            mem_wdata <= nd_wdata;
            mem_wstrb <= nd_wstrb;
          end
        end
        BUSY_I, BUSY_D: if (mem_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (grant_i || !ni_pend)
        starve_cnt <= '0;
      else if (grant_d && starve_cnt != CW'(STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  a_imem_one_outstanding: assert property (@(posedge clk) disable iff (!rst)
    (imem_valid && i_pend) |-> i_ans);
  a_dmem_one_outstanding: assert property (@(posedge clk) disable iff (!rst)
    (dmem_valid && d_pend) |-> d_ans);

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: stimulus queues expected grants and
// responses, a negedge monitor pops and compares as the DUT presents them.
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_valid, dmem_valid, dmem_fence;
  logic [31:0] imem_addr, dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        imem_ready, dmem_ready;
  logic [31:0] imem_rdata, dmem_rdata;
  logic        mem_valid, mem_fence, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  memory_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .imem_valid(imem_valid), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_valid(dmem_valid), .dmem_fence(dmem_fence), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .mem_valid(mem_valid), .mem_fence(mem_fence), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        instr;
    logic        fence;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          cyc;
  } gnt_t;

  gnt_t        gnt_q[$];
  logic [31:0] iresp_q[$];
  logic [31:0] dresp_q[$];
  gnt_t        mg;
  logic [31:0] mr;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rsp_lat = 1;
  bit resp_en = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory model: read data derived from the address, 0x100 holds DEADBEEF.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0000);
  endfunction

  always begin : responder
    logic [31:0] a;
    @(negedge clk);
    if (mem_valid && resp_en && rst) begin
      a = mem_addr;
      repeat (rsp_lat) @(posedge clk);
      #1 mem_ready = 1'b1; mem_rdata = mem_data(a);
      @(posedge clk);
      #1 mem_ready = 1'b0; mem_rdata = '0;
    end
  end

  always @(negedge clk) begin : monitor
    if (rst) begin
      if (mem_valid) begin
        if (gnt_q.size() == 0) chk("mem_valid_spurious", 32'(mem_valid), 32'd0);
        else begin
          mg = gnt_q.pop_front();
          chk("mem_instr", 32'(mem_instr), 32'(mg.instr));
          chk("mem_fence", 32'(mem_fence), 32'(mg.fence));
          chk("mem_addr",  mem_addr, mg.addr);
          chk("mem_wdata", mem_wdata, mg.wdata);
          chk("mem_wstrb", 32'(mem_wstrb), 32'(mg.wstrb));
          if (mg.cyc >= 0) chk("grant_cycle", 32'(cyc), 32'(mg.cyc));
        end
      end
      if (imem_ready) begin
        if (iresp_q.size() == 0) chk("imem_ready_spurious", 32'(imem_ready), 32'd0);
        else begin mr = iresp_q.pop_front(); chk("imem_rdata", imem_rdata, mr); end
      end else chk("imem_rdata_idle", imem_rdata, 32'd0);
      if (dmem_ready) begin
        if (dresp_q.size() == 0) chk("dmem_ready_spurious", 32'(dmem_ready), 32'd0);
        else begin mr = dresp_q.pop_front(); chk("dmem_rdata", dmem_rdata, mr); end
      end else chk("dmem_rdata_idle", dmem_rdata, 32'd0);
    end
  end

  task automatic push_g(input logic instr, input logic fence, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb, input int c);
    gnt_t g;
    g.instr = instr; g.fence = fence; g.addr = addr;
    g.wdata = wdata; g.wstrb = wstrb; g.cyc = c;
    gnt_q.push_back(g);
  endtask

  // Drives a one-cycle request pulse; returns #1 after the capturing edge.
  task automatic issue(input bit iv, input logic [31:0] ia, input bit dv, input bit df,
                       input logic [31:0] da, input logic [31:0] dw, input logic [3:0] ds);
    imem_valid = iv; imem_addr = ia;
    dmem_valid = dv; dmem_fence = df; dmem_addr = da; dmem_wdata = dw; dmem_wstrb = ds;
    @(posedge clk);
    #1;
    imem_valid = 1'b0; dmem_valid = 1'b0; dmem_fence = 1'b0;
    imem_addr = '0; dmem_addr = '0; dmem_wdata = '0; dmem_wstrb = '0;
  endtask

  task automatic wait_ready(input bit is_i, input string nm);
    bit seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      seen = is_i ? imem_ready : dmem_ready;
    end
    if (!seen) chk(nm, 32'd0, 32'd1);
  endtask

  task automatic drain(input string nm);
    bit done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      done = (gnt_q.size() == 0) && (iresp_q.size() == 0) && (dresp_q.size() == 0);
    end
    if (!done) chk(nm, 32'(gnt_q.size() + iresp_q.size() + dresp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int t;
    rst = 1'b0;
    imem_valid = 1'b0; imem_addr = '0;
    dmem_valid = 1'b0; dmem_fence = 1'b0; dmem_addr = '0; dmem_wdata = '0; dmem_wstrb = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_instr", 32'(mem_instr), 32'd0);
    chk("rst_imem_ready", 32'(imem_ready), 32'd0);
    chk("rst_dmem_ready", 32'(dmem_ready), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    // 1: lone fetch, memory answers two cycles after mem_valid
    rsp_lat = 2;
    t = cyc;
    push_g(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, t + 1);
    iresp_q.push_back(32'hDEADBEEF);
    issue(1'b1, 32'h100, 1'b0, 1'b0, '0, '0, '0);
    wait_ready(1'b1, "t1_imem_timeout");
    chk("t1_latency", 32'(cyc), 32'(t + 3));
    drain("t1_drain");
    rsp_lat = 1;

    // 2: simultaneous requests, data wins, fetch follows
    t = cyc;
    push_g(1'b0, 1'b0, 32'h200, 32'h55, 4'hF, t + 1);
    push_g(1'b1, 1'b0, 32'h104, 32'h0, 4'h0, t + 4);
    dresp_q.push_back(32'h5A5A_0200);
    iresp_q.push_back(32'h5A5A_0104);
    issue(1'b1, 32'h104, 1'b1, 1'b0, 32'h200, 32'h55, 4'hF);
    drain("t2_drain");

    // 3: starvation limit; four data grants, then fetch, then counter cleared
    t = cyc;
    for (int k = 0; k < 4; k++) push_g(1'b0, 1'b0, 32'h400 + 32'(4 * k), 32'h0, 4'h0, t + 1 + 3 * k);
    push_g(1'b1, 1'b0, 32'h300, 32'h0, 4'h0, t + 13);
    push_g(1'b0, 1'b0, 32'h410, 32'h0, 4'h0, t + 16);
    push_g(1'b1, 1'b0, 32'h304, 32'h0, 4'h0, t + 19);
    dresp_q.push_back(32'h5A5A_0400); dresp_q.push_back(32'h5A5A_0404);
    dresp_q.push_back(32'h5A5A_0408); dresp_q.push_back(32'h5A5A_040C);
    dresp_q.push_back(32'h5A5A_0410);
    iresp_q.push_back(32'h5A5A_0300); iresp_q.push_back(32'h5A5A_0304);
    issue(1'b1, 32'h300, 1'b1, 1'b0, 32'h400, '0, '0);
    for (int k = 0; k < 4; k++) begin
      wait_ready(1'b0, "t3_dmem_timeout");
      issue(1'b0, '0, 1'b1, 1'b0, 32'h404 + 32'(4 * k), '0, '0);
    end
    wait_ready(1'b1, "t3_imem_timeout");
    issue(1'b1, 32'h304, 1'b0, 1'b0, '0, '0, '0);
    drain("t3_drain");

    // 4: fence passes through with zero strobes
    t = cyc;
    push_g(1'b0, 1'b1, 32'h500, 32'h0, 4'h0, t + 1);
    dresp_q.push_back(32'h5A5A_0500);
    issue(1'b0, '0, 1'b1, 1'b1, 32'h500, '0, '0);
    drain("t4_drain");

    // 5: reset during a data grant, stale mem_ready afterwards is ignored
    resp_en = 1'b0;
    t = cyc;
    push_g(1'b0, 1'b0, 32'h600, 32'hA5, 4'h1, t + 1);
    issue(1'b0, '0, 1'b1, 1'b0, 32'h600, 32'hA5, 4'h1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t5_mem_valid", 32'(mem_valid), 32'd0);
    chk("t5_mem_addr", mem_addr, 32'd0);
    chk("t5_mem_wdata", mem_wdata, 32'd0);
    chk("t5_mem_wstrb", 32'(mem_wstrb), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    mem_ready = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    repeat (2) @(posedge clk);
    #1 mem_ready = 1'b0; mem_rdata = '0;
    resp_en = 1'b1;
    @(posedge clk); #1;
    t = cyc;
    push_g(1'b1, 1'b0, 32'h700, 32'h0, 4'h0, t + 1);
    iresp_q.push_back(32'h5A5A_0700);
    issue(1'b1, 32'h700, 1'b0, 1'b0, '0, '0, '0);
    drain("t5_drain");

    // 6: new data request in its own response cycle
    t = cyc;
    push_g(1'b0, 1'b0, 32'h800, 32'h0, 4'h0, t + 1);
    push_g(1'b0, 1'b0, 32'h804, 32'h1234, 4'h3, t + 4);
    dresp_q.push_back(32'h5A5A_0800);
    dresp_q.push_back(32'h5A5A_0804);
    issue(1'b0, '0, 1'b1, 1'b0, 32'h800, '0, '0);
    wait_ready(1'b0, "t6_dmem_timeout");
    chk("t6_resp_cycle", 32'(cyc), 32'(t + 2));
    issue(1'b0, '0, 1'b1, 1'b0, 32'h804, 32'h1234, 4'h3);
    drain("t6_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
